instr_decode: RTL
=================

// Module: instr_decode
// PURPOSE
//  Instruction-decode (ID) stage directly downstream of the PC/program-memory fetch stage.
//  Accepts one 16-bit instruction per valid/ready handshake and registers it.
//  Splits it into control strobes and operand fields for the execute/RF/data-memory stage.
//  Flags illegal encodings, supports pipeline flush, and keeps retired/illegal instruction counters.
// PARAMETERS
//  DIRECT_LD   2'b10  LD mode field [7:6]: immediate load of instr[15:8]
//  DEFAULT_LD  2'b00  LD mode field [7:6]: load from data memory at instr[15:6]
//  CNT_W       8      width of the o_retired_cnt and o_illegal_cnt counters
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst          in   1      reset, synchronous, active-high
//  i_flush        in   1      drop the registered instruction; no new accept this cycle
//  i_valid        in   1      fetch presents i_instr
//  o_ready        out  1      ID can accept (combinational)
//  i_instr        in   16     {dm_addr[9:0], opcode[3:0], rf_addr[1:0]}
//  o_valid        out  1      decoded outputs valid
//  i_ready        in   1      execute stage accepts
//  o_op           out  4      op_code::full_operation of the registered instruction
//  o_rf_addr      out  2      instr[1:0]
//  o_dm_addr      out  10     instr[15:6]
//  o_imm          out  8      instr[15:8]
//  o_imm_sel      out  1      LD with DIRECT_LD mode
//  o_acc_we       out  1      LD, ADD or XOR_BIT write the accumulator
//  o_rf_we        out  1      ST: accumulator -> RF[o_rf_addr]
//  o_dm_re        out  1      LD with DEFAULT_LD mode
//  o_dm_we        out  1      STM: accumulator -> DM[o_dm_addr]
//  o_illegal      out  1      registered instruction was illegal; all write strobes forced to 0
//  o_retired_cnt  out  CNT_W  count of handshaken instructions, illegal ones included
//  o_illegal_cnt  out  CNT_W  count of handshaken illegal instructions
// BEHAVIOUR
//  - Reset: all outputs 0, o_op = OP_NOP, both counters 0.
//    While i_rst is high, o_ready = 0.
//  - o_ready = !i_rst && !i_flush && (!o_valid || i_ready).
//  - Accept (i_valid && o_ready): next edge registers the decoded fields; o_valid = 1.
//    Latency is 1 cycle.
//  - Output handshake (o_valid && i_ready) with no simultaneous accept: o_valid -> 0.
//  - Simultaneous output handshake and accept: back-to-back transfer; o_valid stays 1.
//    Throughput is 1 instruction per cycle.
//  - Stall (o_valid && !i_ready): every output is held stable.
//    i_instr is not sampled; o_ready = 0.
//  - i_flush: next edge o_valid = 0 and all strobes = 0. Any pending output handshake is discarded.
//    Counters do not increment for a flushed cycle. Flush takes priority over accept.
//  - Illegal conditions:
//    * opcode is not one of NOP/LD/ST/ADD/XOR_BIT/STM;
//    * LD with mode [7:6] not equal to DIRECT_LD or DEFAULT_LD.
//    Result: o_op = OP_NOP, o_illegal = 1, all write/read strobes = 0. The field outputs still carry raw bits.
//  - NOP: legal; all strobes are 0.
//  - Only one of o_acc_we, o_rf_we and o_dm_we may be 1 in any cycle.
//  - Counters increment on the output handshake (o_valid && i_ready && !i_flush).
//    They wrap modulo 2**CNT_W with no saturation.
//  - Strobes are qualified by o_valid: they are 0 whenever o_valid = 0.
//  - Reset asserted mid-stall: the instruction is dropped and the counters clear on that edge.
// TESTING
//  1. Reset, then i_instr={8'hFE,2'b10,OP_LD,2'b00} with i_valid=1, i_ready=1
//     -> next cycle o_valid=1, o_imm=8'hFE, o_imm_sel=1, o_acc_we=1, o_dm_re=0.
//  2. Stream the 7-instruction program LD/ST/LD/ADD/ST/XOR/STM with i_ready=1
//     -> one output per cycle; STM gives o_dm_we=1, o_dm_addr=10'd10; o_retired_cnt=7.
//  3. i_ready=0 for 3 cycles with o_valid=1 -> outputs are stable and o_ready=0.
//     Release -> the next instruction follows with no bubble.
//  4. LD with mode 2'b01, then an undefined opcode -> o_illegal=1, o_op=OP_NOP,
//     strobes=0, o_illegal_cnt=2.
//  5. i_flush while stalled -> next cycle o_valid=0 and the counters are unchanged.
//     Assert i_rst mid-stall -> outputs and counters are 0 on the next edge.
//  6. 256 handshakes with CNT_W=8 -> o_retired_cnt wraps to 0.

Source files
------------

// File: rtl/instr_decode.sv
// instr_decode: ID stage that registers one 16-bit instruction per handshake and decodes it
// into operand fields and write/read strobes, flagging illegal encodings and counting retirements.
module instr_decode #(
    parameter logic [1:0] DIRECT_LD  = 2'b10,
    parameter logic [1:0] DEFAULT_LD = 2'b00,
    parameter int         CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [15:0]      i_instr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [3:0]       o_op,
    output logic [1:0]       o_rf_addr,
    output logic [9:0]       o_dm_addr,
    output logic [7:0]       o_imm,
    output logic             o_imm_sel,
    output logic             o_acc_we,
    output logic             o_rf_we,
    output logic             o_dm_re,
    output logic             o_dm_we,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired_cnt,
    output logic [CNT_W-1:0] o_illegal_cnt
);
    localparam logic [3:0] OP_NOP = 4'd0, OP_LD = 4'd1, OP_ST = 4'd2,
                           OP_ADD = 4'd3, OP_XOR_BIT = 4'd4, OP_STM = 4'd5;

    logic [3:0]       w_op;
    logic [1:0]       w_mode;
    logic             w_known, w_ill, w_accept, w_out_hs;
    logic             r_valid, r_illegal, r_imm_sel, r_acc_we, r_rf_we, r_dm_re, r_dm_we;
    logic [3:0]       r_op;
    logic [15:0]      r_instr;
    logic [CNT_W-1:0] r_retired, r_ill_cnt;

    always_comb begin
        w_op     = i_instr[5:2];
        w_mode   = i_instr[7:6];
        w_known  = w_op <= OP_STM;
        w_ill    = !w_known || (w_op == OP_LD && w_mode != DIRECT_LD && w_mode != DEFAULT_LD);
        o_ready  = !i_rst && !i_flush && (!r_valid || i_ready);
        w_accept = i_valid && o_ready;
        w_out_hs = r_valid && i_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_op      <= OP_NOP;
            r_illegal <= 1'b0;
            r_imm_sel <= 1'b0;
            r_acc_we  <= 1'b0;
            r_rf_we   <= 1'b0;
            r_dm_re   <= 1'b0;
            r_dm_we   <= 1'b0;
            r_retired <= '0;
            r_ill_cnt <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_instr   <= i_instr;
                r_op      <= w_ill ? OP_NOP : w_op;
                r_illegal <= w_ill;
                r_imm_sel <= !w_ill && w_op == OP_LD && w_mode == DIRECT_LD;
                r_acc_we  <= !w_ill && (w_op == OP_LD || w_op == OP_ADD || w_op == OP_XOR_BIT);
                r_rf_we   <= !w_ill && w_op == OP_ST;
                r_dm_re   <= !w_ill && w_op == OP_LD && w_mode == DEFAULT_LD;
                r_dm_we   <= !w_ill && w_op == OP_STM;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_retired <= r_retired + 1'b1;
                r_ill_cnt <= r_ill_cnt + CNT_W'(r_illegal);
            end
        end
    end

    // Strobes are gated by valid so a drained or flushed slot never writes anything.
    always_comb begin
        o_valid       = r_valid;
        o_op          = r_op;
        o_rf_addr     = r_instr[1:0];
        o_dm_addr     = r_instr[15:6];
        o_imm         = r_instr[15:8];
        o_imm_sel     = r_valid && r_imm_sel;
        o_acc_we      = r_valid && r_acc_we;
        o_rf_we       = r_valid && r_rf_we;
        o_dm_re       = r_valid && r_dm_re;
        o_dm_we       = r_valid && r_dm_we;
        o_illegal     = r_valid && r_illegal;
        o_retired_cnt = r_retired;
        o_illegal_cnt = r_ill_cnt;
    end
endmodule
